// File: rtl/demux_1_2_stream_pkg.sv
// Shared widths and helpers for the 1:2 stream demux and its per-channel FIFOs.
// The data and register-address widths match the existing 2:1 select muxes.
package demux_1_2_stream_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 16;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/demux_1_2_stream_chan_fifo.sv
// One output channel: a small synchronous FIFO plus a count of words handed
// to the consumer. The head is forced to zero while empty so no stale word shows.
module demux_1_2_stream_chan_fifo
  import demux_1_2_stream_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [N-1:0]  push_data,
  output logic          full,
  input  logic          pop_ready,
  output logic          valid,
  output logic [N-1:0]  head,
  output logic [CW-1:0] cnt
);

  localparam int PW = ptr_w(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [OW-1:0] occ;
  logic          wr_en;
  logic          rd_en;

  assign full  = (occ == OW'(DEPTH));
  assign valid = (occ != '0);
  // Full is re-checked here so a push can never overrun storage.
  assign wr_en = push & ~full;
  assign rd_en = valid & pop_ready;
  assign head  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
        cnt    <= cnt + CW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever occupancy is zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/demux_1_2_stream.sv
// Steers each accepted input word to channel 0 or 1 by in_sel; each channel
// buffers in its own FIFO so one stalled consumer only blocks words aimed at it.
module demux_1_2_stream
  import demux_1_2_stream_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [N-1:0]  out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [N-1:0]  out1_data,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high. in_ready depends only on in_sel and registered fullness, never
  // on out*_ready, so a pop frees space only from the following cycle.
  logic full0;
  logic full1;
  logic push0;
  logic push1;

  assign in_ready = in_sel ? ~full1 : ~full0;
  // in_valid gates first so an unknown in_sel while idle cannot push.
  assign push0    = in_valid & in_ready & ~in_sel;
  assign push1    = in_valid & in_ready & in_sel;

  demux_1_2_stream_chan_fifo #(.N(N), .DEPTH(DEPTH), .CW(CW)) u_ch0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .pop_ready (out0_ready),
    .valid     (out0_valid),
    .head      (out0_data),
    .cnt       (cnt0)
  );

  demux_1_2_stream_chan_fifo #(.N(N), .DEPTH(DEPTH), .CW(CW)) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop_ready (out1_ready),
    .valid     (out1_valid),
    .head      (out1_data),
    .cnt       (cnt1)
  );

endmodule

// File: tb/tb_demux_1_2_stream.sv
// Directed bench for demux_1_2_stream: inputs change on the falling edge and
// outputs are sampled shortly after it, away from the rising edge.
module tb_demux_1_2_stream;

  localparam int N     = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_sel;
  logic          out0_valid;
  logic          out0_ready;
  logic [N-1:0]  out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [N-1:0]  out1_data;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int checks;
  int failures;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_v;

  demux_1_2_stream #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL reset_out0_valid got=%0h exp=0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL reset_out1_valid got=%0h exp=0", out1_valid); end
    checks++; if (out0_data !== 32'h0) begin failures++; $display("FAIL reset_out0_data got=%h exp=0", out0_data); end
    checks++; if (out1_data !== 32'h0) begin failures++; $display("FAIL reset_out1_data got=%h exp=0", out1_data); end
    checks++; if (cnt0 !== 16'h0) begin failures++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
    checks++; if (cnt1 !== 16'h0) begin failures++; $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); end
    in_sel = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_sel1 got=%0h exp=1", in_ready); end
    // Unknown select while idle must leave both channels empty.
    in_sel = 1'bx; in_data = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    in_sel = 1'b0; #1;
    checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL xsel_out0_valid got=%0h exp=0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL xsel_out1_valid got=%0h exp=0", out1_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL xsel_in_ready got=%0h exp=1", in_ready); end
  endtask

  task automatic test_single_ch0();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF; out0_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%0h exp=1", in_ready); end
    checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0h exp=0", out0_valid); end
    @(negedge clk);
    in_valid = 1'b0; #1;
    checks++; if (out0_valid !== 1'b1) begin failures++; $display("FAIL single_out0_valid got=%0h exp=1", out0_valid); end
    checks++; if (out0_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_out0_data got=%h exp=deadbeef", out0_data); end
    checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL single_out1_valid got=%0h exp=0", out1_valid); end
    @(negedge clk); #1;
    checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%0h exp=0", out0_valid); end
    checks++; if (out0_data !== 32'h0) begin failures++; $display("FAIL single_empty_data got=%h exp=0", out0_data); end
    checks++; if (cnt0 !== 16'd1) begin failures++; $display("FAIL single_cnt0 got=%0d exp=1", cnt0); end
    checks++; if (cnt1 !== 16'd0) begin failures++; $display("FAIL single_cnt1 got=%0d exp=0", cnt1); end
  endtask

  task automatic test_hol_ch1();
    logic accept;
    exp_q.delete();
    @(negedge clk);
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h11; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hol_ready_first got=%0h exp=1", in_ready); end
    exp_q.push_back(32'h11);
    @(negedge clk);
    in_data = 32'h22; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hol_ready_second got=%0h exp=1", in_ready); end
    exp_q.push_back(32'h22);
    @(negedge clk);
    in_data = 32'h33; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hol_full_stall got=%0h exp=0", in_ready); end
    checks++; if (out1_data !== 32'h11) begin failures++; $display("FAIL hol_head got=%h exp=11", out1_data); end
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hol_still_held got=%0h exp=0", in_ready); end
    in_valid = 1'b0; in_sel = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hol_sel0_ready got=%0h exp=1", in_ready); end
    in_sel = 1'b1; in_valid = 1'b1; out1_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hol_no_same_cycle_space got=%0h exp=0", in_ready); end
    for (int c = 0; c < 10 && (exp_q.size() > 0 || in_valid); c++) begin
      accept = 1'b0;
      if (out1_valid && out1_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL hol_unexpected got=%h exp=none", out1_data); end
        else begin
          exp_v = exp_q.pop_front();
          if (out1_data !== exp_v) begin failures++; $display("FAIL hol_order got=%h exp=%h", out1_data, exp_v); end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(in_data); accept = 1'b1; end
      @(negedge clk);
      if (accept) in_valid = 1'b0;
      #1;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL hol_drain_left got=%0d exp=0", exp_q.size()); end
    checks++; if (cnt1 !== 16'd3) begin failures++; $display("FAIL hol_cnt1 got=%0d exp=3", cnt1); end
    checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL hol_out1_empty got=%0h exp=0", out1_valid); end
    in_valid = 1'b0; out1_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    @(negedge clk);
    out0_ready = 1'b0; in_sel = 1'b0; in_valid = 1'b1; in_data = 32'hA0;
    @(negedge clk);
    in_data = 32'hB1;
    @(negedge clk);
    in_data = 32'hC2; out0_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_ready got=%0h exp=0", in_ready); end
    checks++; if (out0_data !== 32'hA0) begin failures++; $display("FAIL full_head_a got=%h exp=a0", out0_data); end
    @(negedge clk);
    out0_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_space_next got=%0h exp=1", in_ready); end
    checks++; if (out0_data !== 32'hB1) begin failures++; $display("FAIL full_head_b got=%h exp=b1", out0_data); end
    checks++; if (cnt0 !== 16'd2) begin failures++; $display("FAIL full_cnt0_pop got=%0d exp=2", cnt0); end
    @(negedge clk);
    in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_refilled got=%0h exp=0", in_ready); end
    out0_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (out0_data !== 32'hC2) begin failures++; $display("FAIL full_head_c got=%h exp=c2", out0_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_one_left_ready got=%0h exp=1", in_ready); end
    @(negedge clk); #1;
    checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%0h exp=0", out0_valid); end
    checks++; if (cnt0 !== 16'd4) begin failures++; $display("FAIL full_cnt0_end got=%0d exp=4", cnt0); end
    out0_ready = 1'b0;
  endtask

  task automatic test_cnt_wrap();
    localparam int NW = (1 << CW) + 3;
    int sent;
    int cyc;
    apply_reset();
    exp_q.delete();
    sent = 0; cyc = 0;
    out1_ready = 1'b1; in_sel = 1'b1;
    while ((sent < NW || exp_q.size() > 0) && cyc < NW + 20) begin
      in_valid = (sent < NW);
      in_data  = (32'(sent) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
      #1;
      if (out1_valid && out1_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_unexpected got=%h exp=none", out1_data); end
        else begin
          exp_v = exp_q.pop_front();
          if (out1_data !== exp_v) begin failures++; $display("FAIL wrap_data got=%h exp=%h", out1_data, exp_v); end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(in_data); sent++; end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; #1;
    checks++; if (sent != NW || exp_q.size() != 0) begin failures++; $display("FAIL wrap_budget got=%0d exp=%0d", sent, NW); end
    checks++; if (cnt1 !== 16'd3) begin failures++; $display("FAIL wrap_cnt1 got=%0d exp=3", cnt1); end
    checks++; if (cnt0 !== 16'd0) begin failures++; $display("FAIL wrap_cnt0 got=%0d exp=0", cnt0); end
    checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL wrap_out1_empty got=%0h exp=0", out1_valid); end
    out1_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h77; out0_ready = 1'b1; out1_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out0_ready = 1'b0; in_valid = 1'b1; in_data = 32'h88;
    @(negedge clk);
    in_data = 32'h99;
    @(negedge clk);
    in_sel = 1'b1; in_data = 32'hAA;
    @(negedge clk);
    in_valid = 1'b0; #1;
    checks++; if (cnt0 !== 16'd1) begin failures++; $display("FAIL ares_pre_cnt0 got=%0d exp=1", cnt0); end
    checks++; if ({out0_valid, out1_valid} !== 2'b11) begin failures++; $display("FAIL ares_pre_valid got=%b exp=11", {out0_valid, out1_valid}); end
    checks++; if (out0_data !== 32'h88) begin failures++; $display("FAIL ares_pre_head0 got=%h exp=88", out0_data); end
    in_sel = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ares_pre_full0 got=%0h exp=0", in_ready); end
    #2;
    rst_n = 1'b0; #1;
    checks++; if ({out0_valid, out1_valid} !== 2'b00) begin failures++; $display("FAIL ares_valid got=%b exp=00", {out0_valid, out1_valid}); end
    checks++; if (out0_data !== 32'h0 || out1_data !== 32'h0) begin failures++; $display("FAIL ares_data got=%h/%h exp=0/0", out0_data, out1_data); end
    checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin failures++; $display("FAIL ares_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ares_in_ready got=%0h exp=1", in_ready); end
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if ({out0_valid, out1_valid} !== 2'b00) begin failures++; $display("FAIL ares_post_valid got=%b exp=00", {out0_valid, out1_valid}); end
    end
    checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin failures++; $display("FAIL ares_post_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_ch0();
    test_hol_ch1();
    test_full_pop();
    test_cnt_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1_2_stream.md
Name: demux_1_2_stream

Overview:
- One-in, two-out steering block: the distribution-side counterpart of the 2:1 select muxes used in the datapath.
- Accepts one N-bit word per valid/ready handshake and routes it, by a per-word select bit, to one of two output channels.
- Each output channel has a small FIFO, so a stalled consumer on one side does not block traffic to the other side until the input word targets the stalled side.
- Used between a shared producer (e.g. writeback/forwarding source) and two consumers.

Parameters:
- N, 32, data width in bits.
- DEPTH, 2, entries per output FIFO (power of two, ≥2).
- CW, 16, width of per-channel transfer counters.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid & in_ready
- in_data  input  N  input word
- in_sel  input  1  destination: 0 → channel 0, 1 → channel 1
- out0_valid  output  1  channel 0 head valid
- out0_ready  input  1  channel 0 consumer accepts
- out0_data  output  N  channel 0 head word
- out1_valid  output  1  channel 1 head valid
- out1_ready  input  1  channel 1 consumer accepts
- out1_data  output  N  channel 1 head word
- cnt0  output  CW  words delivered on channel 0 (handshakes on out0)
- cnt1  output  CW  words delivered on channel 1

Behaviour:
- Reset values (asserted asynchronously, released synchronously to clk):
  - all FIFOs empty
  - rd/wr pointers 0
  - out0_valid = out1_valid = 0
  - out0_data = out1_data = 0
  - cnt0 = cnt1 = 0
- in_ready = !full of the FIFO selected by the current in_sel.
  - Combinational from in_sel and registered FIFO occupancy only; never from out*_ready.
- Push: in_valid & in_ready writes in_data into FIFO[in_sel] at its wr pointer; occupancy +1.
- Pop: outK_valid & outK_ready advances FIFO K's rd pointer; occupancy −1; cntK increments.
- outK_valid = (occupancy K ≠ 0); outK_data = entry at rd pointer K.
  - outK_data is 0 when the FIFO is empty, never stale.
- Latency: a word pushed at edge T appears on outK at T+1 (one cycle), provided FIFO K was empty.
- Ordering: strict FIFO order per channel. No ordering guarantee between channels.
- Simultaneous push and pop on the same channel:
  - If not full: both happen; occupancy unchanged; pointers both advance.
  - If full: in_ready = 0 (registered full), so only the pop happens. Space becomes visible next cycle.
  - If empty: the push lands; out valid rises next cycle. No same-cycle bypass.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap DEPTH−1 → 0. Occupancy is a separate counter, 0..DEPTH.
- Counter wrap: cntK wraps 2^CW−1 → 0 silently.
- Head-of-line: if the input word targets a full channel, the input stalls regardless of space on the other channel. No reordering or lookahead.
- in_sel and in_data may change freely while in_valid = 0. While in_valid & !in_ready, the producer holds in_data/in_sel stable; the block does not check this.
- Reset mid-operation discards all buffered words and counts; in_ready reflects empty FIFOs immediately after reset.
- No X propagation: an X on in_sel while in_valid = 0 must not corrupt state.

Decomposition:
- Shared package holds:
  - default widths (DATA_W = 32, REG_ADDR_W = 5, matching the existing mux widths)
  - DEPTH default
  - a localparam helper for pointer width (clog2)
- One natural sub-module, chan_fifo: synchronous FIFO with push/full/pop/empty/head/occupancy and its transfer counter. Instantiated twice.
- Top level holds only the in_ready select and push steering.

Test Plan:
- Reset then idle → in_ready = 1, both out*_valid = 0, out*_data = 0, cnt0 = cnt1 = 0.
- Push 0xDEAD_BEEF sel = 0 with out0_ready = 1 → out0_valid high exactly one cycle later with 0xDEAD_BEEF; cnt0 = 1; channel 1 untouched.
- out1_ready = 0; push 0x11, 0x22 (sel = 1), then 0x33 (sel = 1) → in_ready drops after the second push; 0x33 held. Switching in_sel to 0 raises in_ready. Releasing out1_ready yields 0x11, 0x22, 0x33 in order.
- Channel 0 full and out0_ready = 1 with in_valid sel = 0 in the same cycle → pop only; in_ready = 1 the next cycle; the word is then accepted; occupancy never exceeds DEPTH.
- Stream 2^CW + 3 words to channel 1 with out1_ready = 1 → cnt1 = 3 after wrap; data matches the sequence across pointer wraps.
- Assert rst_n low mid-stream with both FIFOs holding words → outputs go to reset values without waiting for a clock edge; no buffered word emerges after release.
